// File: rtl/collision_event_scanner_if.sv
// Event stream from the collision scanner to its consumer: valid/ready handshake
// carrying the hit kind and the entity indices involved.
interface collision_event_scanner_if;
   logic       evt_valid;
   logic       evt_ready;
   logic       evt_kind;
   logic [1:0] evt_a;
   logic [1:0] evt_b;

   modport master (output evt_valid, output evt_kind, output evt_a, output evt_b,
                   input  evt_ready);
   modport slave  (input  evt_valid, input  evt_kind, input  evt_a, input  evt_b,
                   output evt_ready);
endinterface

// File: rtl/collision_event_scanner.sv
// Per-frame collision scanner: snapshots four entities, runs four arena-edge
// checks then six pair checks (one per cycle), emitting each hit as an event.
module collision_event_scanner #(
   parameter int unsigned ARENA_W = 640,
   parameter int unsigned ARENA_H = 480
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         frame_start,
   input  logic [39:0]                  posX,
   input  logic [39:0]                  posY,
   input  logic [31:0]                  radius,
   input  logic [3:0]                   active,
   output logic                         busy,
   output logic                         done,
   output logic                         frame_missed,
   collision_event_scanner_if.master    evt
);

   localparam int unsigned N_ENT    = 4;
   localparam int unsigned POS_W    = 10;
   localparam int unsigned RAD_W    = 8;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned LAST_CHK = 9;

   typedef enum logic [1:0] {IDLE, SCAN, EMIT, FINISH} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [4*POS_W-1:0]     sx_q, sx_d, sy_q, sy_d;
   logic [4*RAD_W-1:0]     sr_q, sr_d;
   logic [N_ENT-1:0]       sact_q, sact_d;
   logic                   valid_q, valid_d;
   logic                   kind_q, kind_d;
   logic [1:0]             a_q, a_d, b_q, b_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   missed_q, missed_d;

   logic [POS_W-1:0]       ex [N_ENT];
   logic [POS_W-1:0]       ey [N_ENT];
   logic [RAD_W-1:0]       er [N_ENT];

   logic                   is_pair;
   logic [1:0]             ea, eb;
   logic [POS_W-1:0]       xa, xb, ya, yb, dx, dy;
   logic [RAD_W-1:0]       ra, rb;
   logic [RAD_W:0]         rsum;
   logic                   edge_hit, pair_hit, chk_active, hit, last_chk;

   // Unpack the snapshot into per-entity fields
   always_comb begin
      for (int k = 0; k < N_ENT; k++) begin
         ex[k] = sx_q[k*POS_W +: POS_W];
         ey[k] = sy_q[k*POS_W +: POS_W];
         er[k] = sr_q[k*RAD_W +: RAD_W];
      end
   end

   // Check index to entity selection: 0-3 edge tests, 4-9 pairs in fixed order
   always_comb begin
      is_pair = 1'b1;
      ea      = 2'd0;
      eb      = 2'd0;
      case (idx_q)
         4'd4:    begin ea = 2'd0; eb = 2'd1; end
         4'd5:    begin ea = 2'd0; eb = 2'd2; end
         4'd6:    begin ea = 2'd0; eb = 2'd3; end
         4'd7:    begin ea = 2'd1; eb = 2'd2; end
         4'd8:    begin ea = 2'd1; eb = 2'd3; end
         4'd9:    begin ea = 2'd2; eb = 2'd3; end
         default: begin is_pair = 1'b0; ea = idx_q[1:0]; end
      endcase
   end

   // Hit evaluation; edge sums carried at 11 bits so nothing wraps
   always_comb begin
      xa   = ex[ea];
      xb   = ex[eb];
      ya   = ey[ea];
      yb   = ey[eb];
      ra   = er[ea];
      rb   = er[eb];
      dx   = (xa >= xb) ? (xa - xb) : (xb - xa);
      dy   = (ya >= yb) ? (ya - yb) : (yb - ya);
      rsum = (RAD_W+1)'(ra) + (RAD_W+1)'(rb);

      edge_hit = (11'(ra) >= 11'(xa)) ||
                 ((11'(xa) + 11'(ra)) >= 11'(ARENA_W)) ||
                 (11'(ra) >= 11'(ya)) ||
                 ((11'(ya) + 11'(ra)) >= 11'(ARENA_H));
      pair_hit = (dx <= POS_W'(rsum)) && (dy <= POS_W'(rsum));

      chk_active = is_pair ? (sact_q[ea] && sact_q[eb]) : sact_q[ea];
      hit        = chk_active && (is_pair ? pair_hit : edge_hit);
      last_chk   = (idx_q == IDX_W'(LAST_CHK));
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      sr_d     = sr_q;
      sact_d   = sact_q;
      valid_d  = valid_q;
      kind_d   = kind_q;
      a_d      = a_q;
      b_d      = b_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      missed_d = frame_start && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               sx_d    = posX;
               sy_d    = posY;
               sr_d    = radius;
               sact_d  = active;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               valid_d = 1'b1;
               kind_d  = ~is_pair;
               a_d     = ea;
               b_d     = is_pair ? eb : 2'd0;
               state_d = EMIT;
            end else if (last_chk) begin
               done_d  = 1'b1;
               state_d = FINISH;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         EMIT: begin
            if (evt.evt_ready) begin
               valid_d = 1'b0;
               if (last_chk) begin
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SCAN;
               end
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         sx_q     <= '0;
         sy_q     <= '0;
         sr_q     <= '0;
         sact_q   <= '0;
         valid_q  <= 1'b0;
         kind_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         sr_q     <= sr_d;
         sact_q   <= sact_d;
         valid_q  <= valid_d;
         kind_q   <= kind_d;
         a_q      <= a_d;
         b_q      <= b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         missed_q <= missed_d;
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_kind  = kind_q;
   assign evt.evt_a     = a_q;
   assign evt.evt_b     = b_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign frame_missed  = missed_q;

endmodule

// File: tb/tb_collision_event_scanner.sv
// Directed bench for collision_event_scanner: hand-computed scan latencies,
// event contents, handshake stalls, missed frames and reset behaviour.
module tb_collision_event_scanner;

   logic        Clk;
   logic        Reset;
   logic        frame_start;
   logic [39:0] posX;
   logic [39:0] posY;
   logic [31:0] radius;
   logic [3:0]  active;
   logic        busy;
   logic        done;
   logic        frame_missed;

   int checks   = 0;
   int failures = 0;

   collision_event_scanner_if evt_bus();

   collision_event_scanner #(.ARENA_W(640), .ARENA_H(480)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_start  (frame_start),
      .posX         (posX),
      .posY         (posY),
      .radius       (radius),
      .active       (active),
      .busy         (busy),
      .done         (done),
      .frame_missed (frame_missed),
      .evt          (evt_bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_ent(input int k, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] r);
      posX[k*10 +: 10] = x;
      posY[k*10 +: 10] = y;
      radius[k*8 +: 8] = r;
   endtask

   task automatic cfg_sep();
      set_ent(0, 10'd100, 10'd240, 8'd10);
      set_ent(1, 10'd200, 10'd240, 8'd10);
      set_ent(2, 10'd300, 10'd240, 8'd10);
      set_ent(3, 10'd400, 10'd240, 8'd10);
   endtask

   task automatic cfg_edge();
      cfg_sep();
      set_ent(0, 10'd5, 10'd240, 8'd8);
   endtask

   task automatic cfg_pair();
      set_ent(0, 10'd300, 10'd300, 8'd8);
      set_ent(1, 10'd100, 10'd100, 8'd8);
      set_ent(2, 10'd115, 10'd100, 8'd8);
      set_ent(3, 10'd500, 10'd300, 8'd8);
   endtask

   // Pulse frame_start and run to done with evt_ready held 1. cyc counts the
   // frame_start cycle as 1; mod_at>0 rewrites entity 0 X and re-pulses
   // frame_start at that cycle.
   task automatic run_scan(input int mod_at, output int cyc, output int nev,
                           output logic [4:0] ev, output int nmiss, output logic busy1);
      cyc = 1; nev = 0; ev = '0; nmiss = 0;
      frame_start = 1'b1;
      tick(); cyc++;
      frame_start = 1'b0;
      busy1 = busy;
      while (cyc < 60) begin
         if (evt_bus.evt_valid) begin
            nev++;
            if (nev == 1) ev = {evt_bus.evt_kind, evt_bus.evt_a, evt_bus.evt_b};
         end
         if (frame_missed) nmiss++;
         if (done) break;
         if (cyc == mod_at) begin
            posX[9:0]   = 10'd5;
            frame_start = 1'b1;
         end else begin
            frame_start = 1'b0;
         end
         tick(); cyc++;
      end
      frame_start = 1'b0;
   endtask

   int          cyc, nev, nmiss, ndone;
   logic [4:0]  ev;
   logic        busy1;

   initial begin
      Reset = 1'b1; frame_start = 1'b0; active = 4'hF;
      posX = '0; posY = '0; radius = '0;
      evt_bus.evt_ready = 1'b1;
      tick(); tick();
      chk("rst_valid",  32'(evt_bus.evt_valid), 0);
      chk("rst_kind",   32'(evt_bus.evt_kind), 0);
      chk("rst_a",      32'(evt_bus.evt_a), 0);
      chk("rst_b",      32'(evt_bus.evt_b), 0);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_done",   32'(done), 0);
      chk("rst_missed", 32'(frame_missed), 0);
      Reset = 1'b0;
      tick();

      // Separated entities: no events, minimum latency
      cfg_sep(); active = 4'hF;
      run_scan(0, cyc, nev, ev, nmiss, busy1);
      chk("sep_busy_after_start", 32'(busy1), 1);
      chk("sep_events", 32'(nev), 0);
      chk("sep_done_cycle", 32'(cyc), 12);
      chk("sep_busy_in_finish", 32'(busy), 1);
      tick();
      chk("sep_busy_cleared", 32'(busy), 0);
      chk("sep_done_pulse", 32'(done), 0);

      // Entity 0 touches the left edge
      cfg_edge();
      run_scan(0, cyc, nev, ev, nmiss, busy1);
      chk("edge_events", 32'(nev), 1);
      chk("edge_fields", 32'(ev), 32'(5'b1_00_00));
      chk("edge_done_cycle", 32'(cyc), 13);
      tick();

      // Overlapping pair (1,2) with a 5-cycle consumer stall
      cfg_pair(); active = 4'hF;
      evt_bus.evt_ready = 1'b0;
      frame_start = 1'b1; cyc = 1;
      tick(); cyc++;
      frame_start = 1'b0;
      while (!evt_bus.evt_valid && cyc < 40) begin tick(); cyc++; end
      chk("pair_first_valid_cycle", 32'(cyc), 10);
      for (int i = 0; i < 5; i++) begin
         tick(); cyc++;
         chk("pair_hold", 32'({evt_bus.evt_valid, evt_bus.evt_kind, evt_bus.evt_a, evt_bus.evt_b}),
             32'(6'b1_0_01_10));
      end
      evt_bus.evt_ready = 1'b1;
      tick(); cyc++;
      chk("pair_accept_drops_valid", 32'(evt_bus.evt_valid), 0);
      while (!done && cyc < 60) begin tick(); cyc++; end
      chk("pair_done_cycle", 32'(cyc), 18);
      tick();

      // Same overlap with entity 2 inactive
      active = 4'b1011;
      run_scan(0, cyc, nev, ev, nmiss, busy1);
      chk("pair_inactive_events", 32'(nev), 0);
      chk("pair_inactive_done_cycle", 32'(cyc), 12);
      tick();

      // Nothing active, even with an edge-hitting configuration
      cfg_edge(); active = 4'b0000;
      run_scan(0, cyc, nev, ev, nmiss, busy1);
      chk("none_active_events", 32'(nev), 0);
      chk("none_active_done_cycle", 32'(cyc), 12);
      tick();

      // Inputs change mid-scan and frame_start arrives while busy
      cfg_sep(); active = 4'hF;
      run_scan(4, cyc, nev, ev, nmiss, busy1);
      chk("snap_events", 32'(nev), 0);
      chk("snap_done_cycle", 32'(cyc), 12);
      chk("snap_missed_pulses", 32'(nmiss), 1);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done || busy) ndone++;
      end
      chk("snap_no_second_scan", 32'(ndone), 0);

      // frame_start coinciding with done is missed
      cfg_sep();
      run_scan(0, cyc, nev, ev, nmiss, busy1);
      chk("coincide_done_cycle", 32'(cyc), 12);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("coincide_missed", 32'(frame_missed), 1);
      chk("coincide_busy", 32'(busy), 0);
      tick();
      chk("coincide_no_restart", 32'(busy), 0);
      chk("coincide_missed_one_cycle", 32'(frame_missed), 0);

      // Reset while an event is stalled in EMIT
      cfg_edge(); active = 4'hF;
      evt_bus.evt_ready = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      cyc = 0;
      while (!evt_bus.evt_valid && cyc < 20) begin tick(); cyc++; end
      chk("emit_reached", 32'(evt_bus.evt_valid), 1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("emit_rst_valid", 32'(evt_bus.evt_valid), 0);
      chk("emit_rst_busy", 32'(busy), 0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) ndone++;
         tick();
      end
      chk("emit_rst_no_done", 32'(ndone), 0);

      // Reset wins over frame_start in the same cycle
      Reset = 1'b1; frame_start = 1'b1;
      tick();
      Reset = 1'b0; frame_start = 1'b0;
      tick();
      chk("rst_priority_busy", 32'(busy), 0);

      // A full scan runs normally after reset
      evt_bus.evt_ready = 1'b1;
      cfg_sep();
      run_scan(0, cyc, nev, ev, nmiss, busy1);
      chk("post_rst_events", 32'(nev), 0);
      chk("post_rst_done_cycle", 32'(cyc), 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/collision_event_scanner.md
COLLISION_EVENT_SCANNER -- requirements
Module: collision_event_scanner

Interface
REQ-001 Parameter ARENA_W, default 640: arena right edge in pixels.
REQ-002 Parameter ARENA_H, default 480: arena bottom edge in pixels.
REQ-003 Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse that starts a scan of the current frame.
REQ-006 posX  input  40  four 10-bit entity X centres; entity k occupies bits [10k+9:10k].
REQ-007 posY  input  40  four 10-bit entity Y centres, packed the same way.
REQ-008 radius  input  32  four 8-bit half-extents; entity k occupies bits [8k+7:8k].
REQ-009 active  input  4  bit k set means entity k takes part in the scan.
REQ-010 evt_ready  input  1  consumer accepts the presented event this cycle.
REQ-011 evt_valid  output  1  an event is being presented.
REQ-012 evt_kind  output  1  0 = entity-pair hit, 1 = arena-edge hit.
REQ-013 evt_a  output  2  first entity index, or the edge-hit entity.
REQ-014 evt_b  output  2  second entity index; 0 when evt_kind=1.
REQ-015 busy  output  1  a scan is in progress.
REQ-016 done  output  1  one-cycle pulse when a scan completes.
REQ-017 frame_missed  output  1  one-cycle pulse when frame_start arrives while busy.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN, EMIT and FINISH.
- IDLE + frame_start: snapshot posX, posY, radius and active into internal registers; clear check index to 0; go to SCAN; busy=1 from the next cycle.
REQ-019 SCAN SHALL evaluate one check per cycle from the snapshot in fixed order.
- Checks 0-3: edge test of entity 0..3.
- Checks 4-9: pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
REQ-020 A check whose entity, or either pair member, is inactive SHALL be skipped with no event.
REQ-021 The edge hit SHALL be: radius >= posX, or posX + radius >= ARENA_W, or radius >= posY, or posY + radius >= ARENA_H.
- Evaluate at 11-bit width; no wrap-around.
REQ-022 The pair hit SHALL be |Xi-Xj| <= ri+rj AND |Yi-Yj| <= ri+rj.
- Absolute differences are 10-bit; the radius sum is 9-bit, unsigned.
REQ-023 On a hit, SCAN SHALL latch the event fields, assert evt_valid and go to EMIT.
REQ-024 In EMIT, evt_valid and all evt_* fields SHALL remain stable until the cycle with evt_ready=1.
- In that cycle: deassert evt_valid next cycle, advance index, return to SCAN.
REQ-025 After check 9 is finished (hit accepted or no hit), the FSM SHALL enter FINISH.
- FINISH: pulse done for one cycle, clear busy, return to IDLE.
REQ-026 Minimum scan latency with no hits SHALL be 12 cycles from frame_start to done.
- 1 snapshot cycle + 10 check cycles + 1 FINISH cycle.
REQ-027 frame_start while busy SHALL be ignored for scanning and SHALL pulse frame_missed for exactly one cycle.
REQ-028 Input changes during a scan SHALL NOT affect that scan; only the snapshot is used.
REQ-029 frame_start in the same cycle as done SHALL be treated as missed.
- A new scan starts only from IDLE.
REQ-030 A scan with active=4'b0000 SHALL produce no events and done after 12 cycles.

Reset
REQ-031 Reset SHALL force IDLE, evt_valid=0, evt_kind=0, evt_a=0, evt_b=0, busy=0, done=0, frame_missed=0, and clear the check index and snapshot registers.
REQ-032 Reset mid-scan or mid-EMIT SHALL abandon the scan with no done pulse.
- Reset has priority over frame_start in the same cycle.

Verification
REQ-033 All four entities active and separated (X=100,200,300,400; Y=240; r=10), evt_ready=1 -> no evt_valid; done 12 cycles after frame_start.
REQ-034 Entity 0 at X=5, r=8, others clear -> one event kind=1, a=0, b=0; done follows.
REQ-035 Entity 1 at (100,100) and entity 2 at (115,100), r=8 each (diff 15 <= 16), evt_ready held 0 for 5 cycles -> evt_valid and fields stable for 5 cycles; event kind=0, a=1, b=2 accepted on the ready cycle.
REQ-036 Entities 1 and 2 overlapping as above but active=4'b1011 -> no event.
REQ-037 Change posX mid-scan; pulse frame_start while busy -> results reflect the snapshot; frame_missed pulses once; no second scan.
REQ-038 Assert Reset during EMIT -> next cycle evt_valid=0, busy=0, no done; a following frame_start runs a full scan.
